// File: rtl/pinmux_pkg.sv
// -----------------------------------------------------------------------------
// pinmux_pkg
//   Shared types and helpers for the pin multiplexer.
//   pin_state_e     : per-pin FSM state (ACTIVE drives the selected function,
//                     SETTLE holds the pad tri-stated while a new function is
//                     being switched in)
//   fsel_w()        : width of a function-select field, never below 1 bit
//   idx_w()         : width of a pin index, never below 1 bit
//   IDLE_IN_DEFAULT : level seen by a peripheral input that is not routed
// -----------------------------------------------------------------------------
package pinmux_pkg;

  typedef enum logic {
    PIN_ACTIVE = 1'b0,
    PIN_SETTLE = 1'b1
  } pin_state_e;

  localparam logic IDLE_IN_DEFAULT = 1'b1;

  function automatic int fsel_w(input int num_funcs);
    return (num_funcs > 1) ? $clog2(num_funcs) : 1;
  endfunction

  function automatic int idx_w(input int num_items);
    return (num_items > 1) ? $clog2(num_items) : 1;
  endfunction

endpackage

// File: rtl/pinmux_pin_slot.sv
// -----------------------------------------------------------------------------
// pinmux_pin_slot
//   One pad of the pin multiplexer: function-select registers, the
//   ACTIVE/SETTLE state machine with its settle counter, the output mux
//   towards the pad and the input demux towards the peripherals.
// Ports
//   clk, rst         clock, synchronous active-high reset
//   wr_en, wr_fsel   accepted write for this pin and the requested function
//   gpio_o/_oe_n     GPIO output data / active-low enable for this pin
//   func_o/_oe_n     peripheral output data / enable, bit f-1 = function f
//   pad_sync         synchronised pad input
//   func_i           peripheral inputs, bit f-1 = function f
//   pad_o, pad_oe_n  pad output data / active-low enable
//   act_fsel         function currently driving the pad
//   busy             pin is in the settle state
// -----------------------------------------------------------------------------
module pinmux_pin_slot
  import pinmux_pkg::*;
#(
  parameter int   NUM_FUNCS     = 4,
  parameter int   SETTLE_CYCLES = 3,
  parameter int   RESET_FUNC    = 0,
  parameter logic IDLE_IN       = IDLE_IN_DEFAULT,
  parameter int   FSEL_W        = fsel_w(NUM_FUNCS),
  parameter int   PF_W          = (NUM_FUNCS > 1) ? NUM_FUNCS - 1 : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [FSEL_W-1:0] wr_fsel,
  input  logic              gpio_o,
  input  logic              gpio_oe_n,
  input  logic [PF_W-1:0]   func_o,
  input  logic [PF_W-1:0]   func_oe_n,
  input  logic              pad_sync,
  output logic [PF_W-1:0]   func_i,
  output logic              pad_o,
  output logic              pad_oe_n,
  output logic [FSEL_W-1:0] act_fsel,
  output logic              busy
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [FSEL_W-1:0] FSEL_RST = FSEL_W'(RESET_FUNC);

  pin_state_e        state_q, state_d;
  logic [FSEL_W-1:0] act_q, act_d;
  logic [FSEL_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PIN_ACTIVE;
      act_q   <= FSEL_RST;
      pend_q  <= FSEL_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state: any write while settling restarts the full settle window,
  // even one that asks for the function already on the pad
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    case (state_q)
      PIN_ACTIVE: begin
        if (wr_en && (wr_fsel != act_q)) begin
          if (SETTLE_CYCLES == 0) begin
            act_d = wr_fsel;
          end else begin
            state_d = PIN_SETTLE;
            pend_d  = wr_fsel;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      PIN_SETTLE: begin
        if (wr_en) begin
          pend_d = wr_fsel;
          cnt_d  = CNT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = PIN_ACTIVE;
          act_d   = pend_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = PIN_ACTIVE;
    endcase
  end

  // outputs: function 0 is GPIO; during settle the pad floats with data high
  // and no peripheral sees the pad
  always_comb begin
    pad_o    = gpio_o;
    pad_oe_n = gpio_oe_n;
    func_i   = {PF_W{IDLE_IN}};
    for (int f = 1; f < NUM_FUNCS; f++) begin
      if (act_q == FSEL_W'(f)) begin
        pad_o       = func_o[f-1];
        pad_oe_n    = func_oe_n[f-1];
        func_i[f-1] = pad_sync;
      end
    end
    if (state_q == PIN_SETTLE) begin
      pad_o    = 1'b1;
      pad_oe_n = 1'b1;
      func_i   = {PF_W{IDLE_IN}};
    end
  end

  assign act_fsel = act_q;
  assign busy     = (state_q == PIN_SETTLE);

endmodule

// File: rtl/pinmux_ctrl.sv
// -----------------------------------------------------------------------------
// pinmux_ctrl
//   Register-programmed pin multiplexer between GPIO, peripheral alternate
//   functions and the pad ring. Holds the configuration decode, the sticky
//   lock, the error pulse and the pad-input synchroniser; one pinmux_pin_slot
//   per pad does the per-pin switching.
// Ports
//   wb_clk_i, wb_rst_i    clock, synchronous active-high reset
//   cfg_we/addr/wdata     one-cycle write of a pin's function select
//   cfg_lock              sticky write lock (set-only until reset)
//   cfg_rdata             active function of pin cfg_addr (combinational)
//   cfg_busy              per pin, 1 while settling
//   cfg_err               one-cycle pulse after a rejected write
//   gpio_o/_oe_n, gpio_i  GPIO side; gpio_i is the synchronised pad input
//   func_o/_oe_n, func_i  peripheral side, bit (f-1)*NUM_PINS+pin
//   pad_i, pad_o/_oe_n    pad ring side
// -----------------------------------------------------------------------------
module pinmux_ctrl
  import pinmux_pkg::*;
#(
  parameter int   NUM_PINS      = 24,
  parameter int   NUM_FUNCS     = 4,
  parameter int   SYNC_STAGES   = 2,
  parameter int   SETTLE_CYCLES = 3,
  parameter int   RESET_FUNC    = 0,
  parameter logic IDLE_IN       = IDLE_IN_DEFAULT
) (
  input  logic                              wb_clk_i,
  input  logic                              wb_rst_i,
  input  logic                              cfg_we,
  input  logic [idx_w(NUM_PINS)-1:0]        cfg_addr,
  input  logic [fsel_w(NUM_FUNCS)-1:0]      cfg_wdata,
  input  logic                              cfg_lock,
  output logic [fsel_w(NUM_FUNCS)-1:0]      cfg_rdata,
  output logic [NUM_PINS-1:0]               cfg_busy,
  output logic                              cfg_err,
  input  logic [NUM_PINS-1:0]               gpio_o,
  input  logic [NUM_PINS-1:0]               gpio_oe_n,
  output logic [NUM_PINS-1:0]               gpio_i,
  input  logic [(NUM_FUNCS-1)*NUM_PINS-1:0] func_o,
  input  logic [(NUM_FUNCS-1)*NUM_PINS-1:0] func_oe_n,
  output logic [(NUM_FUNCS-1)*NUM_PINS-1:0] func_i,
  input  logic [NUM_PINS-1:0]               pad_i,
  output logic [NUM_PINS-1:0]               pad_o,
  output logic [NUM_PINS-1:0]               pad_oe_n
);

  localparam int FSEL_W = fsel_w(NUM_FUNCS);
  localparam int ADDR_W = idx_w(NUM_PINS);
  localparam int PF_W   = NUM_FUNCS - 1;

  logic              lock_q;
  logic              err_q;
  logic              lock_eff;
  logic              wr_ok;
  logic [FSEL_W-1:0] act_fsel [NUM_PINS];
  logic [NUM_PINS-1:0] pad_sync;

  // a lock raised in the same cycle as a write already blocks that write
  assign lock_eff = lock_q | cfg_lock;
  assign wr_ok    = cfg_we && !lock_eff
                    && (32'(cfg_addr) < NUM_PINS)
                    && (32'(cfg_wdata) < NUM_FUNCS);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      lock_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      lock_q <= lock_eff;
      err_q  <= cfg_we && !wr_ok;
    end
  end

  assign cfg_err = err_q;

  generate
    if (SYNC_STAGES == 0) begin : g_sync_bypass
      assign pad_sync = pad_i;
    end else begin : g_sync
      logic [NUM_PINS-1:0] sync_p [SYNC_STAGES];
      always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
          for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_p[s] <= {NUM_PINS{IDLE_IN}};
          end
        end else begin
          // stage 0 captures the raw pad, later stages retime it
          sync_p[0] <= pad_i;
          for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_p[s] <= sync_p[s-1];
          end
        end
      end
      assign pad_sync = sync_p[SYNC_STAGES-1];
    end
  endgenerate

  assign gpio_i = pad_sync;

  for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
    logic [PF_W-1:0] pin_func_o;
    logic [PF_W-1:0] pin_func_oe_n;
    logic [PF_W-1:0] pin_func_i;

    for (genvar f = 0; f < PF_W; f++) begin : g_func
      assign pin_func_o[f]          = func_o[f*NUM_PINS+p];
      assign pin_func_oe_n[f]       = func_oe_n[f*NUM_PINS+p];
      assign func_i[f*NUM_PINS+p]   = pin_func_i[f];
    end

    pinmux_pin_slot #(
      .NUM_FUNCS     (NUM_FUNCS),
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .RESET_FUNC    (RESET_FUNC),
      .IDLE_IN       (IDLE_IN),
      .FSEL_W        (FSEL_W),
      .PF_W          (PF_W)
    ) u_slot (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .wr_en     (wr_ok && (cfg_addr == ADDR_W'(p))),
      .wr_fsel   (cfg_wdata),
      .gpio_o    (gpio_o[p]),
      .gpio_oe_n (gpio_oe_n[p]),
      .func_o    (pin_func_o),
      .func_oe_n (pin_func_oe_n),
      .pad_sync  (pad_sync[p]),
      .func_i    (pin_func_i),
      .pad_o     (pad_o[p]),
      .pad_oe_n  (pad_oe_n[p]),
      .act_fsel  (act_fsel[p]),
      .busy      (cfg_busy[p])
    );
  end

  always_comb begin
    cfg_rdata = '0;
    for (int p = 0; p < NUM_PINS; p++) begin
      if (cfg_addr == ADDR_W'(p)) begin
        cfg_rdata = act_fsel[p];
      end
    end
  end

endmodule

// File: tb/tb_pinmux_ctrl.sv
module tb_pinmux_ctrl;

  localparam int NP  = 24;
  localparam int NF  = 4;
  localparam int SS  = 2;
  localparam int SC  = 3;
  localparam int PFW = NF - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [4:0]        cfg_addr;
  logic [1:0]        cfg_wdata;
  logic              cfg_lock;
  logic [1:0]        cfg_rdata;
  logic [NP-1:0]     cfg_busy;
  logic              cfg_err;
  logic [NP-1:0]     gpio_o, gpio_oe_n, gpio_i;
  logic [PFW*NP-1:0] func_o, func_oe_n, func_i;
  logic [NP-1:0]     pad_i, pad_o, pad_oe_n;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  pinmux_ctrl dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_lock  (cfg_lock),
    .cfg_rdata (cfg_rdata),
    .cfg_busy  (cfg_busy),
    .cfg_err   (cfg_err),
    .gpio_o    (gpio_o),
    .gpio_oe_n (gpio_oe_n),
    .gpio_i    (gpio_i),
    .func_o    (func_o),
    .func_oe_n (func_oe_n),
    .func_i    (func_i),
    .pad_i     (pad_i),
    .pad_o     (pad_o),
    .pad_oe_n  (pad_oe_n)
  );

  task automatic chk(input string name, input logic [127:0] got,
                     input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each pin: function on the pad, function waiting, and number of
  // remaining safe-state cycles (0 = function live on the pad).
  int            m_act  [NP];
  int            m_pend [NP];
  int            m_rem  [NP];
  bit            m_lock, m_err, m_valid = 0;
  bit            m_lk, m_acc;
  logic [NP-1:0] m_hist [$];

  always @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NP; p++) begin
        m_act[p] = 0; m_pend[p] = 0; m_rem[p] = 0;
      end
      m_lock = 0; m_err = 0;
      m_hist = {};
      for (int s = 0; s < SS; s++) m_hist.push_back({NP{1'b1}});
      m_valid = 1;
    end else if (m_valid) begin
      m_lk  = m_lock || cfg_lock;
      m_acc = cfg_we && !m_lk && (cfg_addr < NP) && (cfg_wdata < NF);
      m_err = cfg_we && !m_acc;
      m_lock = m_lk;
      for (int p = 0; p < NP; p++) begin
        if (m_rem[p] > 0) begin
          if (m_acc && cfg_addr == p) begin
            m_pend[p] = cfg_wdata; m_rem[p] = SC;
          end else begin
            m_rem[p]--;
            if (m_rem[p] == 0) m_act[p] = m_pend[p];
          end
        end else if (m_acc && cfg_addr == p && cfg_wdata != m_act[p]) begin
          if (SC == 0) m_act[p] = cfg_wdata;
          else begin m_pend[p] = cfg_wdata; m_rem[p] = SC; end
        end
      end
      m_hist.push_back(pad_i);
      void'(m_hist.pop_front());
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [NP-1:0]     e_po, e_oe, e_busy, e_gi;
  logic [PFW*NP-1:0] e_fi;

  always @(negedge clk) begin
    if (m_valid) begin
      e_gi = m_hist[0];
      for (int p = 0; p < NP; p++) begin
        e_busy[p] = (m_rem[p] > 0);
        if (m_rem[p] > 0) begin
          e_po[p] = 1'b1; e_oe[p] = 1'b1;
        end else if (m_act[p] == 0) begin
          e_po[p] = gpio_o[p]; e_oe[p] = gpio_oe_n[p];
        end else begin
          e_po[p] = func_o[(m_act[p]-1)*NP+p];
          e_oe[p] = func_oe_n[(m_act[p]-1)*NP+p];
        end
        for (int f = 1; f < NF; f++)
          e_fi[(f-1)*NP+p] = (m_rem[p] == 0 && m_act[p] == f) ? e_gi[p] : 1'b1;
      end
      chk("pad_o", pad_o, e_po);
      chk("pad_oe_n", pad_oe_n, e_oe);
      chk("cfg_busy", cfg_busy, e_busy);
      chk("gpio_i", gpio_i, e_gi);
      chk("func_i", func_i, e_fi);
      chk("cfg_err", cfg_err, m_err);
      if (cfg_addr < NP) chk("cfg_rdata", cfg_rdata, m_act[cfg_addr]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic nxt();
    @(posedge clk); #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; cfg_lock = 0;
    gpio_o = 24'hA5A5A5; gpio_oe_n = 24'h000000;
    func_o    = {24'hC3C3C3, 24'h5A5A5A, 24'h00FF00};
    func_oe_n = {24'hFFFFFF, 24'h000000, 24'h0F0F0F};
    pad_i = '0;
    repeat (3) @(posedge clk);
    #2 rst = 0;

    // reset state
    @(negedge clk);
    chk("rst_pad_o", pad_o, 24'hA5A5A5);
    chk("rst_pad_oe_n", pad_oe_n, 24'h000000);
    chk("rst_busy", cfg_busy, 24'h000000);
    chk("rst_gpio_i", gpio_i, 24'hFFFFFF);
    chk("rst_func_i", func_i, {72{1'b1}});
    chk("rst_rdata", cfg_rdata, 2'd0);
    chk("rst_err", cfg_err, 1'b0);

    // pin 13 -> func 2 with three safe cycles
    nxt(); cfg_we = 1; cfg_addr = 13; cfg_wdata = 2;
    nxt(); cfg_we = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("p13_settle_busy", cfg_busy[13], 1'b1);
      chk("p13_settle_oe_n", pad_oe_n[13], 1'b1);
      chk("p13_settle_o", pad_o[13], 1'b1);
      chk("p13_settle_rdata", cfg_rdata, 2'd0);
    end
    @(negedge clk);
    chk("p13_live_busy", cfg_busy[13], 1'b0);
    chk("p13_live_o", pad_o[13], 1'b0);
    chk("p13_live_oe_n", pad_oe_n[13], 1'b0);
    chk("p13_live_rdata", cfg_rdata, 2'd2);

    // pin 12: func 2 then func 1 one cycle later, settle restarts
    nxt(); cfg_we = 1; cfg_addr = 12; cfg_wdata = 2;
    nxt(); cfg_wdata = 1;
    nxt(); cfg_we = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("p12_restart_busy", cfg_busy[12], 1'b1);
      chk("p12_restart_rdata", cfg_rdata, 2'd0);
    end
    @(negedge clk);
    chk("p12_live_busy", cfg_busy[12], 1'b0);
    chk("p12_live_rdata", cfg_rdata, 2'd1);
    chk("p12_live_oe_n", pad_oe_n[12], 1'b0);
    chk("p12_live_o", pad_o[12], 1'b1);

    // same-function write is a no-op
    nxt(); cfg_we = 1; cfg_addr = 13; cfg_wdata = 2;
    nxt(); cfg_we = 0;
    @(negedge clk);
    chk("noop_busy", cfg_busy, 24'h000000);
    chk("noop_err", cfg_err, 1'b0);

    // out-of-range pin index
    nxt(); cfg_we = 1; cfg_addr = 30; cfg_wdata = 1;
    nxt(); cfg_we = 0; cfg_addr = 13;
    @(negedge clk);
    chk("badaddr_err", cfg_err, 1'b1);
    chk("badaddr_busy", cfg_busy, 24'h000000);
    @(negedge clk);
    chk("badaddr_err_clear", cfg_err, 1'b0);

    // GPIO pass-through on the func-0 pins
    nxt(); gpio_o = 24'h3C3C3C; gpio_oe_n = 24'hF0F0F0;
    @(negedge clk);
    chk("gpio_pass_o", pad_o[7:0], 8'h3C);
    chk("gpio_pass_oe_n", pad_oe_n[7:0], 8'hF0);

    // input path on pin 17 with func 1
    nxt(); cfg_we = 1; cfg_addr = 17; cfg_wdata = 1;
    nxt(); cfg_we = 0;
    repeat (4) nxt();
    pad_i[17] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("p17_sync_lat", gpio_i[17], 1'b0);
    @(negedge clk);
    chk("p17_gpio_rise", gpio_i[17], 1'b1);
    chk("p17_f1_rise", func_i[17], 1'b1);
    nxt(); pad_i[17] = 1'b0;
    repeat (3) @(negedge clk);
    chk("p17_gpio_fall", gpio_i[17], 1'b0);
    chk("p17_f1_fall", func_i[17], 1'b0);
    chk("p17_f2_idle", func_i[NP+17], 1'b1);
    chk("p17_f3_idle", func_i[2*NP+17], 1'b1);

    // reset in the middle of a settle on pin 5
    nxt(); cfg_we = 1; cfg_addr = 5; cfg_wdata = 3;
    nxt(); cfg_we = 0; rst = 1;
    @(negedge clk);
    chk("p5_pre_rst_busy", cfg_busy[5], 1'b1);
    nxt(); rst = 0;
    @(negedge clk);
    chk("p5_rst_busy", cfg_busy, 24'h000000);
    chk("p5_rst_rdata", cfg_rdata, 2'd0);
    chk("p5_rst_oe_n", pad_oe_n[5], gpio_oe_n[5]);
    chk("p13_rst_o", pad_o[13], gpio_o[13]);

    // lock: same-cycle write is rejected, later writes too
    nxt(); cfg_we = 1; cfg_addr = 3; cfg_wdata = 1; cfg_lock = 1;
    nxt(); cfg_we = 0; cfg_lock = 0;
    @(negedge clk);
    chk("lock_same_err", cfg_err, 1'b1);
    chk("lock_same_busy", cfg_busy, 24'h000000);
    nxt(); cfg_we = 1; cfg_addr = 3; cfg_wdata = 2;
    nxt(); cfg_we = 0;
    @(negedge clk);
    chk("lock_later_err", cfg_err, 1'b1);
    chk("lock_later_busy", cfg_busy, 24'h000000);
    chk("lock_later_rdata", cfg_rdata, 2'd0);

    repeat (3) nxt();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
